// File: rtl/fpmul_arbiter.sv
// Two-requester round-robin front end for a shared strobe/ack floating-point multiplier.
// Holds one operation at a time and runs a sticky watchdog on the multiplier-side waits.
module fpmul_arbiter #(
    parameter logic [7:0] WDOG_MAX = 8'd200
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        r0_valid,
    input  logic [31:0] r0_a,
    input  logic [31:0] r0_b,
    output logic        r0_ready,
    output logic [31:0] r0_z,
    output logic        r0_z_valid,
    input  logic        r0_z_ready,
    input  logic        r1_valid,
    input  logic [31:0] r1_a,
    input  logic [31:0] r1_b,
    output logic        r1_ready,
    output logic [31:0] r1_z,
    output logic        r1_z_valid,
    input  logic        r1_z_ready,
    output logic [31:0] m_ia,
    output logic [31:0] m_ib,
    output logic        m_stb_a,
    output logic        m_stb_b,
    input  logic        m_i_ack,
    input  logic [31:0] m_z,
    input  logic        m_z_stb,
    output logic        m_z_ack,
    output logic        busy,
    output logic        grant,
    output logic        timeout,
    output logic [15:0] op_count
);

    typedef enum logic [2:0] {IDLE, SEND_A, SEND_B, WAIT_Z, RESP} state_t;

    state_t     state;
    logic       last_grant;
    logic [7:0] wdog;
    logic       req_any;
    logic       pick;
    logic       resp_ready;

    // Round-robin choice: a lone requester wins, a tie goes to the one not served last.
    always_comb begin
        req_any    = r0_valid | r1_valid;
        pick       = r1_valid;
        resp_ready = grant ? r1_z_ready : r0_z_ready;
        if (r0_valid && r1_valid) begin
            pick = ~last_grant;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            last_grant <= 1'b1;
            grant      <= 1'b0;
            busy       <= 1'b0;
            wdog       <= 8'd0;
            timeout    <= 1'b0;
            op_count   <= 16'd0;
            r0_ready   <= 1'b0;
            r1_ready   <= 1'b0;
            r0_z       <= 32'd0;
            r1_z       <= 32'd0;
            r0_z_valid <= 1'b0;
            r1_z_valid <= 1'b0;
            m_ia       <= 32'd0;
            m_ib       <= 32'd0;
            m_stb_a    <= 1'b0;
            m_stb_b    <= 1'b0;
            m_z_ack    <= 1'b0;
        end else begin
            r0_ready <= 1'b0;
            r1_ready <= 1'b0;

            // Watchdog only runs while waiting on the multiplier; any state change clears it below.
            if (state == SEND_A || state == SEND_B || state == WAIT_Z) begin
                if (wdog == WDOG_MAX) begin
                    timeout <= 1'b1;
                end else begin
                    wdog <= wdog + 8'd1;
                end
            end

            case (state)
                IDLE: begin
                    if (req_any) begin
                        grant      <= pick;
                        last_grant <= pick;
                        r0_ready   <= ~pick;
                        r1_ready   <= pick;
                        m_ia       <= pick ? r1_a : r0_a;
                        m_ib       <= pick ? r1_b : r0_b;
                        m_stb_a    <= 1'b1;
                        busy       <= 1'b1;
                        wdog       <= 8'd0;
                        state      <= SEND_A;
                    end
                end
                SEND_A: begin
                    if (m_stb_a && m_i_ack) begin
                        m_stb_a <= 1'b0;
                        m_stb_b <= 1'b1;
                        wdog    <= 8'd0;
                        state   <= SEND_B;
                    end
                end
                SEND_B: begin
                    if (m_stb_b && m_i_ack) begin
                        m_stb_b <= 1'b0;
                        m_z_ack <= 1'b1;
                        wdog    <= 8'd0;
                        state   <= WAIT_Z;
                    end
                end
                WAIT_Z: begin
                    if (m_z_stb && m_z_ack) begin
                        m_z_ack  <= 1'b0;
                        op_count <= op_count + 16'd1;
                        wdog     <= 8'd0;
                        state    <= RESP;
                        if (grant) begin
                            r1_z       <= m_z;
                            r1_z_valid <= 1'b1;
                        end else begin
                            r0_z       <= m_z;
                            r0_z_valid <= 1'b1;
                        end
                    end
                end
                RESP: begin
                    if (resp_ready) begin
                        r0_z_valid <= 1'b0;
                        r1_z_valid <= 1'b0;
                        busy       <= 1'b0;
                        wdog       <= 8'd0;
                        state      <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fpmul_arbiter.sv
// Self-checking bench for fpmul_arbiter: directed scenarios plus a randomized phase
// checked against a round-robin / result-routing reference model.
module tb_fpmul_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        r0_valid, r0_ready, r0_z_valid, r0_z_ready;
    logic [31:0] r0_a, r0_b, r0_z;
    logic        r1_valid, r1_ready, r1_z_valid, r1_z_ready;
    logic [31:0] r1_a, r1_b, r1_z;
    logic [31:0] m_ia, m_ib, m_z;
    logic        m_stb_a, m_stb_b, m_i_ack, m_z_stb, m_z_ack;
    logic        busy, grant, timeout;
    logic [15:0] op_count;

    fpmul_arbiter #(.WDOG_MAX(8'd200)) dut (
        .clk(clk), .rst(rst),
        .r0_valid(r0_valid), .r0_a(r0_a), .r0_b(r0_b), .r0_ready(r0_ready),
        .r0_z(r0_z), .r0_z_valid(r0_z_valid), .r0_z_ready(r0_z_ready),
        .r1_valid(r1_valid), .r1_a(r1_a), .r1_b(r1_b), .r1_ready(r1_ready),
        .r1_z(r1_z), .r1_z_valid(r1_z_valid), .r1_z_ready(r1_z_ready),
        .m_ia(m_ia), .m_ib(m_ib), .m_stb_a(m_stb_a), .m_stb_b(m_stb_b),
        .m_i_ack(m_i_ack), .m_z(m_z), .m_z_stb(m_z_stb), .m_z_ack(m_z_ack),
        .busy(busy), .grant(grant), .timeout(timeout), .op_count(op_count)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int passes = 0;
    int fails  = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Stand-in multiplier: exact IEEE products for the named cases, an opaque mix otherwise.
    function automatic logic [31:0] mul_model(input logic [31:0] a, input logic [31:0] b);
        if ((a == 32'h40000000 && b == 32'h40400000) || (a == 32'h40400000 && b == 32'h40000000))
            return 32'h40C00000;
        if (a == 32'h3FC00000 && b == 32'hC0000000) return 32'hC0400000;
        if (a == 32'h7F800000 && b == 32'h00000000) return 32'hFFC00000;
        return a ^ {b[15:0], b[31:16]} ^ 32'h5A5A0F0F;
    endfunction

    // Multiplier-side agent: samples and drives on the falling edge.
    int          ms = 0, cnt = 0, lat = 1;
    bit          z_hold = 1'b0, ack_rand = 1'b0;
    logic [31:0] ma = '0, mb = '0, s_ia = '0, s_ib = '0;
    logic        s_stb_a = 1'b0, s_stb_b = 1'b0, s_zack = 1'b0;

    initial begin
        m_i_ack = 1'b0; m_z_stb = 1'b0; m_z = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                ms = 0; cnt = 0; m_i_ack = 1'b0; m_z_stb = 1'b0; m_z = '0;
            end else begin
                if (ms == 0 && m_i_ack && s_stb_a) begin ma = s_ia; ms = 1; end
                else if (ms == 1 && m_i_ack && s_stb_b) begin mb = s_ib; ms = 2; cnt = lat; end
                else if (ms == 3 && m_z_stb && s_zack) ms = 0;
                if (ms == 2) begin
                    if (cnt == 0) ms = 3;
                    else cnt--;
                end
                m_i_ack = (ms < 2) ? (ack_rand ? 1'($urandom_range(0, 1)) : 1'b1) : 1'b0;
                m_z_stb = (ms == 3) && !z_hold;
                m_z     = (ms == 3) ? mul_model(ma, mb) : 32'h0;
            end
            s_stb_a = m_stb_a; s_stb_b = m_stb_b; s_zack = m_z_ack;
            s_ia = m_ia; s_ib = m_ib;
        end
    end

    task automatic wait_grant(output int who);
        who = -1;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (r0_ready) begin who = 0; break; end
            if (r1_ready) begin who = 1; break; end
        end
    endtask

    task automatic wait_z(input int n, output logic [31:0] z, output logic ok);
        ok = 1'b0; z = '0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (n == 0 && r0_z_valid) begin ok = 1'b1; z = r0_z; break; end
            if (n == 1 && r1_z_valid) begin ok = 1'b1; z = r1_z; break; end
        end
    endtask

    task automatic wait_zack(output logic ok);
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (m_z_ack) begin ok = 1'b1; break; end
        end
    endtask

    task automatic reset_pulse();
        @(negedge clk); #1 rst = 1'b1;
        @(negedge clk); #1 rst = 1'b0;
    endtask

    int          who;
    logic [31:0] z, zsave;
    logic        ok, seen;

    initial begin
        rst = 1'b1;
        r0_valid = 0; r0_a = '0; r0_b = '0; r0_z_ready = 0;
        r1_valid = 0; r1_a = '0; r1_b = '0; r1_z_ready = 0;
        repeat (3) @(negedge clk);
        chk("reset_ctl", 32'({busy, grant, timeout, m_stb_a, m_stb_b, m_z_ack,
                              r0_ready, r1_ready, r0_z_valid, r1_z_valid}), 32'h0);
        chk("reset_cnt", 32'(op_count), 32'h0);
        chk("reset_data", r0_z | r1_z | m_ia | m_ib, 32'h0);
        #1 rst = 1'b0;

        // r0 alone: 2.0 x 3.0
        @(negedge clk);
        r0_valid = 1; r0_a = 32'h40000000; r0_b = 32'h40400000;
        wait_grant(who);
        r0_valid = 0;
        chk("t1_grant", 32'(who), 32'd0);
        chk("t1_status", 32'({busy, grant}), 32'b10);
        @(negedge clk);
        chk("t1_ready_pulse", 32'(r0_ready), 32'd0);
        chk("t1_m_ia", m_ia, 32'h40000000);
        chk("t1_m_ib", m_ib, 32'h40400000);
        wait_z(0, z, ok);
        chk("t1_zvalid", 32'(ok), 32'd1);
        chk("t1_z", z, 32'h40C00000);
        chk("t1_opcount", 32'(op_count), 32'd1);
        repeat (3) @(negedge clk);
        chk("t1_zvalid_held", 32'(r0_z_valid), 32'd1);
        r0_z_ready = 1;
        @(negedge clk);
        chk("t1_after_hs", 32'({r0_z_valid, busy}), 32'd0);
        chk("t1_z_stable", r0_z, 32'h40C00000);
        chk("t1_r1_untouched", r1_z | 32'(r1_z_valid), 32'd0);

        // tie after reset: r0 first, then r1, then r0 wins the next tie
        reset_pulse();
        r1_z_ready = 1;
        r0_valid = 1; r0_a = 32'h3FC00000; r0_b = 32'hC0000000;
        r1_valid = 1; r1_a = 32'h40000000; r1_b = 32'h40400000;
        wait_grant(who);
        chk("t2_first", 32'(who), 32'd0);
        chk("t2_no_r1_ready", 32'(r1_ready), 32'd0);
        r0_valid = 0;
        wait_z(0, z, ok);
        chk("t2_r0_z", z, 32'hC0400000);
        wait_grant(who);
        r1_valid = 0;
        chk("t2_second", 32'(who), 32'd1);
        wait_z(1, z, ok);
        chk("t2_r1_z", z, 32'h40C00000);
        r0_valid = 1; r0_a = 32'h11112222; r0_b = 32'h33334444;
        r1_valid = 1; r1_a = 32'h55556666; r1_b = 32'h77778888;
        wait_grant(who);
        r0_valid = 0; r1_valid = 0;
        chk("t2_tie_again", 32'(who), 32'd0);
        wait_z(0, z, ok);
        chk("t2_tie_z", z, mul_model(32'h11112222, 32'h33334444));

        // r1: inf x 0
        @(negedge clk);
        r1_valid = 1; r1_a = 32'h7F800000; r1_b = 32'h00000000;
        wait_grant(who);
        r1_valid = 0;
        chk("t3_grant", 32'(who), 32'd1);
        wait_z(1, z, ok);
        chk("t3_nan", z, 32'hFFC00000);

        // response back-pressure while r1 waits
        @(negedge clk);
        r0_z_ready = 0;
        r0_valid = 1; r0_a = 32'h0BADF00D; r0_b = 32'h12345678;
        wait_grant(who);
        r0_valid = 0;
        r1_valid = 1; r1_a = 32'hCAFEBABE; r1_b = 32'h01020304;
        wait_z(0, zsave, ok);
        chk("t4_z", zsave, mul_model(32'h0BADF00D, 32'h12345678));
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            chk("t4_hold", 32'({r0_z_valid, r1_ready, busy}), 32'b101);
        end
        chk("t4_z_stable", r0_z, zsave);
        r0_z_ready = 1;
        @(negedge clk);
        chk("t4_hs", 32'({r0_z_valid, r1_ready, busy}), 32'b000);
        @(negedge clk);
        chk("t4_r1_granted", 32'({r1_ready, grant}), 32'b11);
        r1_valid = 0;
        wait_z(1, z, ok);
        chk("t4_r1_z", z, mul_model(32'hCAFEBABE, 32'h01020304));

        // watchdog: stall the result beyond WDOG_MAX
        @(negedge clk);
        z_hold = 1;
        r0_valid = 1; r0_a = 32'h40000000; r0_b = 32'h40400000;
        wait_grant(who);
        r0_valid = 0;
        wait_zack(ok);
        chk("t5_wait_z", 32'(ok), 32'd1);
        repeat (190) @(negedge clk);
        chk("t5_no_early_timeout", 32'(timeout), 32'd0);
        repeat (20) @(negedge clk);
        chk("t5_timeout", 32'({timeout, r0_z_valid, busy}), 32'b101);
        z_hold = 0;
        wait_z(0, z, ok);
        chk("t5_z", z, 32'h40C00000);
        @(negedge clk);
        chk("t5_sticky", 32'({timeout, busy}), 32'b10);
        reset_pulse();
        chk("t5_rst_clears", 32'(timeout), 32'd0);

        // reset during WAIT_Z
        @(negedge clk);
        z_hold = 1;
        r1_valid = 1; r1_a = 32'h40000000; r1_b = 32'h40400000;
        wait_grant(who);
        r1_valid = 0;
        wait_zack(ok);
        chk("t6_wait_z", 32'(ok), 32'd1);
        @(negedge clk); #1 rst = 1'b1;
        #1;
        chk("t6_async_ctl", 32'({busy, grant, m_z_ack, r1_z_valid, timeout}), 32'd0);
        chk("t6_async_data", 32'(op_count) | r1_z | m_ia | m_ib, 32'd0);
        @(negedge clk); #1 rst = 1'b0;
        z_hold = 0;
        seen = 1'b0;
        repeat (8) begin
            @(negedge clk);
            seen = seen | r1_z_valid | r0_z_valid;
        end
        chk("t6_no_response", 32'(seen), 32'd0);
        r1_valid = 1; r1_a = 32'h3FC00000; r1_b = 32'hC0000000;
        wait_grant(who);
        r1_valid = 0;
        chk("t6_regrant", 32'(who), 32'd1);
        wait_z(1, z, ok);
        chk("t6_z", z, 32'hC0400000);
        chk("t6_opcount", 32'(op_count), 32'd1);

        // randomized traffic against the reference model
        begin
            logic [31:0] ra[2], rb[2], expz[2];
            bit          pend[2], vld[2], pv[2];
            int          rr_last, done, win;
            logic [15:0] exp_cnt;
            rr_last = 1; done = 0; exp_cnt = 16'd1;
            pend = '{0, 0}; vld = '{0, 0}; pv = '{0, 0};
            ack_rand = 1;
            for (int c = 0; c < 4000 && done < 40; c++) begin
                @(negedge clk);
                lat = $urandom_range(0, 3);
                if (r0_ready || r1_ready) begin
                    win = (pv[0] && pv[1]) ? 1 - rr_last : (pv[1] ? 1 : 0);
                    chk("rand_grant", 32'({r1_ready, r0_ready}), win ? 32'b10 : 32'b01);
                    rr_last = win;
                    vld[win] = 0;
                end
                for (int n = 0; n < 2; n++) begin
                    if (n == 0 ? r0_z_valid : r1_z_valid) begin
                        chk("rand_z", n == 0 ? r0_z : r1_z, expz[n]);
                        pend[n] = 0;
                        done++;
                        exp_cnt = exp_cnt + 16'd1;
                        chk("rand_opcount", 32'(op_count), 32'(exp_cnt));
                    end
                end
                for (int n = 0; n < 2; n++) begin
                    if (!pend[n] && $urandom_range(0, 2) == 0) begin
                        ra[n] = $urandom; rb[n] = $urandom;
                        expz[n] = mul_model(ra[n], rb[n]);
                        pend[n] = 1; vld[n] = 1;
                    end
                end
                r0_valid = vld[0]; r0_a = ra[0]; r0_b = rb[0];
                r1_valid = vld[1]; r1_a = ra[1]; r1_b = rb[1];
                pv = vld;
            end
            chk("rand_done", 32'(done >= 40), 32'd1);
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: observed no finish, expected finish before 2ms");
        $fatal(1, "simulation timeout");
    end

endmodule

// File: doc/fpmul_arbiter.md
FPMUL_ARBITER -- requirements
Module: fpmul_arbiter

Interface
REQ-001 SHALL have parameter WDOG_MAX, default 8'd200, which sets the number of stalled cycles on the multiplier side before the timeout flag is raised.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit: asynchronous active-high reset.
REQ-004 SHALL have, per requester n in {0,1}, these ports:
- rn_valid, input, 1 bit.
- rn_a, input, 32 bits; rn_b, input, 32 bits: IEEE-754 single-precision operands.
- rn_ready, output, 1 bit: one-cycle operand-accept pulse.
- rn_z, output, 32 bits: result.
- rn_z_valid, output, 1 bit.
- rn_z_ready, input, 1 bit.
REQ-005 SHALL have these multiplier-side ports:
- m_ia, output, 32 bits; m_ib, output, 32 bits.
- m_stb_a, output, 1 bit; m_stb_b, output, 1 bit.
- m_i_ack, input, 1 bit.
- m_z, input, 32 bits; m_z_stb, input, 1 bit.
- m_z_ack, output, 1 bit.
REQ-006 SHALL have these status outputs:
- busy, output, 1 bit.
- grant, output, 1 bit: the requester currently being served.
- timeout, output, 1 bit: sticky.
- op_count, output, 16 bits: completed operations.

Function
REQ-007 SHALL implement the states IDLE, SEND_A, SEND_B, WAIT_Z and RESP; busy=1 in every state except IDLE.
REQ-008 SHALL arbitrate in IDLE as follows:
- Only one rn_valid high: grant that requester.
- Both high: grant the requester not granted last (round-robin).
- After reset, requester 0 wins the first tie.
REQ-009 SHALL, on a grant in IDLE, in the same cycle:
- pulse rn_ready for exactly one cycle;
- register rn_a/rn_b into internal operand registers;
- update grant and last-grant;
- go to SEND_A on the next edge.
REQ-010 SHALL keep m_ia and m_ib driven from the operand registers, stable from SEND_A until the state returns to IDLE.
REQ-011 SHALL handle the A transfer as follows:
- In SEND_A, hold m_stb_a=1.
- The transfer occurs on the edge where m_stb_a and m_i_ack are both 1; go to SEND_B.
- m_stb_a=0 in every state other than SEND_A.
REQ-012 SHALL handle the B transfer as follows:
- In SEND_B, hold m_stb_b=1.
- Transfer on the edge where m_stb_b and m_i_ack are both 1; go to WAIT_Z.
- m_stb_b=0 in every other state.
REQ-013 SHALL handle the result as follows:
- In WAIT_Z, hold m_z_ack=1.
- On the edge where m_z_stb and m_z_ack are both 1, capture m_z into the granted requester's rn_z register, increment op_count, and go to RESP.
- m_z_ack=0 in every other state.
REQ-014 SHALL handle the response as follows:
- In RESP, hold rn_z_valid=1 for the granted requester only.
- On the edge where rn_z_valid and rn_z_ready are both 1, drop rn_z_valid and return to IDLE.
- rn_z holds its value until it is next overwritten.
REQ-015 SHALL never grant a new operation until RESP completes, even if a requester drops rn_valid mid-operation (the operation completes regardless).
REQ-016 SHALL run an 8-bit watchdog counter in SEND_A, SEND_B and WAIT_Z:
- Clear it on every state change.
- Saturate it at WDOG_MAX.
- Reaching WDOG_MAX sets timeout=1.
- The FSM keeps waiting; it does not abort.
REQ-017 SHALL wrap op_count from 16'hFFFF to 16'h0000.
REQ-018 SHALL treat results as opaque 32-bit words; the arbiter performs no arithmetic on operands or results.
REQ-019 SHALL achieve a minimum latency from the rn_ready pulse to rn_z_valid rising of 2 + the multiplier latency in cycles, with no idle bubble added by the arbiter beyond one IDLE cycle between operations.

Reset
REQ-020 SHALL on rst=1, asynchronously and for as long as rst is held, force:
- state=IDLE.
- All strobes, acks, rn_ready and rn_z_valid = 0.
- grant=0, last-grant=1.
- timeout=0, op_count=0, watchdog=0.
- rn_z=0, m_ia=0, m_ib=0.
REQ-021 SHALL, when reset is asserted mid-operation, drop any in-flight result with no response; the multiplier shares rst and also returns to its operand-wait state.
REQ-022 SHALL take its first grant on the first rising edge after rst falls at which some rn_valid=1.

Verification
REQ-023 SHALL cover this case: r0 alone, a=32'h40000000, b=32'h40400000 -> r0_z=32'h40C00000, r0_z_valid until r0_z_ready, op_count=1, r1 untouched.
REQ-024 SHALL cover this case: r0 and r1 valid in the same cycle after reset (r0: 32'h3FC00000 x 32'hC0000000; r1: 2.0 x 3.0) -> r0 served first with 32'hC0400000, then r1 with 32'h40C00000; a following tie grants r0 again.
REQ-025 SHALL cover this case: r1 operands 32'h7F800000 x 32'h00000000 -> r1_z=32'hFFC00000.
REQ-026 SHALL cover this case: r0_z_ready held low 20 cycles in RESP -> r0_z_valid stays high and rn_z stable; no new grant while r1_valid is high; r1 is granted one cycle after the r0 response handshake.
REQ-027 SHALL cover this case: m_z_stb forced low beyond WDOG_MAX cycles -> timeout=1 and stays 1 after the result finally arrives; rst clears it.
REQ-028 SHALL cover this case: rst pulsed during WAIT_Z -> outputs immediately at reset values, no rn_z_valid, op_count=0; a new request then completes normally.
